// File: rtl/ws2811_pixel_serializer_pkg.sv
// Shared types and default timing for the ws2811 pixel serializer.
// The timing defaults assume a 40 MHz masterClk driving an 800 kHz bit stream.
package ws2811_pixel_serializer_pkg;

  localparam int WS2811_BIT_CYC   = 50;
  localparam int WS2811_RESET_CYC = 2400;
  localparam int WS2811_STB_CYC   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } serState_e;

  function automatic int maxInt(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ws2811_pixel_serializer_if.sv
// Pixel word handshake between a frame producer (master) and the serializer (slave).
interface ws2811_pixel_serializer_if;

  logic [23:0] pixelData;
  logic        pixelLast;
  logic        pixelValid;
  logic        pixelReady;

  modport master (output pixelData, output pixelLast, output pixelValid, input pixelReady);
  modport slave  (input pixelData, input pixelLast, input pixelValid, output pixelReady);

endinterface

// File: rtl/ws2811_pixel_serializer.sv
// Serializes 24-bit GRB pixel words into one data bit plus one strobe per slot for the
// ws2811 encoder. After the last pixel it holds the line idle for the latch gap.
module ws2811_pixel_serializer
  import ws2811_pixel_serializer_pkg::*;
#(
  parameter int BIT_CYC   = WS2811_BIT_CYC,
  parameter int RESET_CYC = WS2811_RESET_CYC,
  parameter int STB_CYC   = WS2811_STB_CYC
) (
  input  logic                            masterClk,
  input  logic                            nReset,
  ws2811_pixel_serializer_if.slave        pixelBus,
  output logic                            serData,
  output logic                            serClk,
  output logic                            busy,
  output logic                            frameDone,
  output logic                            underrun
);

  localparam int CW = $clog2(maxInt(BIT_CYC, RESET_CYC));
  localparam logic [CW-1:0] CYC_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] STB_END  = CW'(STB_CYC);

  serState_e      state;
  serState_e      stateNext;
  logic [23:0]    shiftReg;
  logic [23:0]    shiftNext;
  logic           curLast;
  logic           lastNext;
  logic [4:0]     bitCnt;
  logic [4:0]     bitNext;
  logic [CW-1:0]  cycCnt;
  logic [CW-1:0]  cycNext;
  logic           pixelReadyReg;
  logic           readyNext;
  logic           accept;
  logic           serDataNext;
  logic           serClkNext;
  logic           doneNext;
  logic           underNext;

  assign pixelBus.pixelReady = pixelReadyReg;

  // Next-state and next-output decode; outputs are derived from the next state so they register cleanly.
  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    lastNext  = curLast;
    bitNext   = bitCnt;
    cycNext   = cycCnt;
    underNext = 1'b0;
    accept    = pixelBus.pixelValid && pixelReadyReg;

    case (state)
      ST_IDLE: begin
        cycNext = CYC_ZERO;
        if (accept) begin
          stateNext = ST_SHIFT;
          shiftNext = pixelBus.pixelData;
          lastNext  = pixelBus.pixelLast;
          bitNext   = 5'd23;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cycCnt != BIT_LAST) begin
          cycNext = cycCnt + CYC_ONE;
        end else if (bitCnt != 5'd0) begin
          bitNext = bitCnt - 5'd1;
          cycNext = CYC_ZERO;
        end else if (curLast) begin
          stateNext = ST_LATCH;
          cycNext   = CYC_ZERO;
        end else if (accept) begin
          // Next word follows in the very next slot, no idle gap on the line.
          shiftNext = pixelBus.pixelData;
          lastNext  = pixelBus.pixelLast;
          bitNext   = 5'd23;
          cycNext   = CYC_ZERO;
        end else begin
          stateNext = ST_IDLE;
          cycNext   = CYC_ZERO;
          underNext = 1'b1;
        end
      end
      ST_LATCH: begin
        if (cycCnt == RST_LAST) begin
          stateNext = ST_IDLE;
          cycNext   = CYC_ZERO;
        end else begin
          cycNext = cycCnt + CYC_ONE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cycNext   = CYC_ZERO;
      end
    endcase

    serDataNext = (stateNext == ST_SHIFT) ? shiftNext[bitNext] : 1'b0;
    serClkNext  = (stateNext == ST_SHIFT) && (cycNext >= CYC_ONE) && (cycNext <= STB_END);
    doneNext    = (stateNext == ST_LATCH) && (cycNext == RST_LAST);
    readyNext   = (stateNext == ST_IDLE) ||
                  ((stateNext == ST_SHIFT) && (cycNext == BIT_LAST) &&
                   (bitNext == 5'd0) && !lastNext);
  end

  // State, counters and registered outputs; reset drops serClk at once so no stray edge reaches the encoder.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      state         <= ST_IDLE;
      shiftReg      <= 24'd0;
      curLast       <= 1'b0;
      bitCnt        <= 5'd0;
      cycCnt        <= CYC_ZERO;
      pixelReadyReg <= 1'b0;
      serData       <= 1'b0;
      serClk        <= 1'b0;
      busy          <= 1'b0;
      frameDone     <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state         <= stateNext;
      shiftReg      <= shiftNext;
      curLast       <= lastNext;
      bitCnt        <= bitNext;
      cycCnt        <= cycNext;
      pixelReadyReg <= readyNext;
      serData       <= serDataNext;
      serClk        <= serClkNext;
      busy          <= (stateNext != ST_IDLE);
      frameDone     <= doneNext;
      underrun      <= underNext;
    end
  end

endmodule

// File: tb/tb_ws2811_pixel_serializer.sv
// Bench for ws2811_pixel_serializer: a slot-timeline model predicts every output on every cycle,
// plus frame-level checks on edge counts, sampled bits and latency.
module tb_ws2811_pixel_serializer;

  localparam int BIT  = 50;
  localparam int RST  = 2400;
  localparam int STB  = 2;
  localparam int BITS = 24 * BIT;

  logic masterClk = 1'b0;
  logic nReset    = 1'b0;
  logic serData, serClk, busy, frameDone, underrun;

  ws2811_pixel_serializer_if pixBus();

  ws2811_pixel_serializer #(.BIT_CYC(BIT), .RESET_CYC(RST), .STB_CYC(STB)) dut (
    .masterClk (masterClk),
    .nReset    (nReset),
    .pixelBus  (pixBus),
    .serData   (serData),
    .serClk    (serClk),
    .busy      (busy),
    .frameDone (frameDone),
    .underrun  (underrun)
  );

  always #5 masterClk = ~masterClk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: time since the most recent accepted word decides every output
  bit          act = 1'b0;
  int          hStart = 0;
  logic [23:0] mWord = 24'd0;
  logic        mLast = 1'b0;
  int          sinceRst = 0;
  bit          lastHs = 1'b0;

  // observed-event bookkeeping
  int          edgeCnt = 0;
  logic [23:0] edgeBits = 24'd0;
  int          lastEdgeCyc = 0;
  int          doneCnt = 0;
  int          lastDoneCyc = 0;
  int          underCnt = 0;
  int          readyBusyCnt = 0;
  logic        prevSerClk = 1'b0;

  task automatic chkBit(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", nm, cyc, a, e);
    end
  endtask

  task automatic chkInt(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, a, e);
    end
  endtask

  task automatic cmpCycle();
    logic eData, eClk, eBusy, eDone, eUnder, eReady;
    int   k;
    bit   hs;
    eData = 1'b0; eClk = 1'b0; eBusy = 1'b0; eDone = 1'b0; eUnder = 1'b0; eReady = 1'b0;
    hs = 1'b0;
    if (nReset !== 1'b1) begin
      act      = 1'b0;
      sinceRst = 0;
    end else begin
      k = cyc - hStart;
      if (act && k >= 1 && k <= BITS) begin
        eData  = mWord[23 - (k - 1) / BIT];
        eClk   = ((k - 1) % BIT >= 1) && ((k - 1) % BIT <= STB);
        eBusy  = 1'b1;
        eReady = (k == BITS) && !mLast;
      end else if (act && mLast && k > BITS && k <= BITS + RST) begin
        eBusy = 1'b1;
        eDone = (k == BITS + RST);
      end else begin
        eReady = (sinceRst >= 1);
        eUnder = act && !mLast && (k == BITS + 1);
      end
      hs = (pixBus.pixelValid === 1'b1) && eReady;
      sinceRst++;
    end
    chkBit("serData", serData, eData);
    chkBit("serClk", serClk, eClk);
    chkBit("busy", busy, eBusy);
    chkBit("frameDone", frameDone, eDone);
    chkBit("underrun", underrun, eUnder);
    chkBit("pixelReady", pixBus.pixelReady, eReady);

    if (serClk === 1'b1 && prevSerClk === 1'b0) begin
      edgeCnt++;
      edgeBits    = {edgeBits[22:0], serData};
      lastEdgeCyc = cyc;
    end
    prevSerClk = serClk;
    if (frameDone === 1'b1) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
    if (underrun === 1'b1) underCnt++;
    if (pixBus.pixelReady === 1'b1 && busy === 1'b1) readyBusyCnt++;

    if (hs) begin
      act    = 1'b1;
      hStart = cyc;
      mWord  = pixBus.pixelData;
      mLast  = pixBus.pixelLast;
    end
    lastHs = hs;
    cyc++;
  endtask

  task automatic step();
    @(negedge masterClk);
    cmpCycle();
    @(posedge masterClk);
    #2;
  endtask

  task automatic idle(input int n);
    pixBus.pixelValid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sendWord(input logic [23:0] w, input logic l, input bit hold);
    pixBus.pixelValid = 1'b1;
    pixBus.pixelData  = w;
    pixBus.pixelLast  = l;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (lastHs) break;
    end
    chkBit("handshake_seen", lastHs, 1'b1);
    if (!hold) pixBus.pixelValid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int d0;
    d0 = doneCnt;
    pixBus.pixelValid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (doneCnt != d0) break;
    end
  endtask

  initial begin
    int e0, d0, u0, r0, h0, n, gap;
    logic [23:0] wa, wb;

    // reset held with valid high: everything stays quiet
    pixBus.pixelValid = 1'b1;
    pixBus.pixelData  = 24'hFFFFFF;
    pixBus.pixelLast  = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chkInt("rst_no_edges", edgeCnt, 0);
    pixBus.pixelValid = 1'b0;
    nReset = 1'b1;
    step();
    step();
    chkBit("rel_ready", pixBus.pixelReady, 1'b1);

    // single pixel with hand-derived expectations
    e0 = edgeCnt; d0 = doneCnt;
    sendWord(24'hA50F3C, 1'b1, 1'b0);
    h0 = hStart;
    waitDone(4000);
    chkInt("s1_edges", edgeCnt - e0, 24);
    chkInt("s1_bits", int'(edgeBits), int'(24'hA50F3C));
    chkInt("s1_done_lat", lastDoneCyc - h0, 3600);
    chkInt("s1_done_cnt", doneCnt - d0, 1);

    // three back-to-back pixels, valid held
    e0 = edgeCnt; d0 = doneCnt; u0 = underCnt; r0 = readyBusyCnt;
    sendWord(24'($urandom()), 1'b0, 1'b1);
    h0 = hStart;
    sendWord(24'($urandom()), 1'b0, 1'b1);
    sendWord(24'($urandom()), 1'b1, 1'b0);
    waitDone(5000);
    chkInt("b2b_edges", edgeCnt - e0, 72);
    chkInt("b2b_last_edge", lastEdgeCyc - h0, 2 + 71 * BIT);
    chkInt("b2b_ready_pulses", readyBusyCnt - r0, 2);
    chkInt("b2b_underrun", underCnt - u0, 0);
    chkInt("b2b_done", doneCnt - d0, 1);

    // gap after a non-last pixel: underrun, then resume
    e0 = edgeCnt; d0 = doneCnt; u0 = underCnt;
    sendWord(24'($urandom()), 1'b0, 1'b0);
    idle(BITS + 200);
    wb = 24'($urandom());
    sendWord(wb, 1'b1, 1'b0);
    waitDone(5000);
    chkInt("ur_underrun", underCnt - u0, 1);
    chkInt("ur_edges", edgeCnt - e0, 48);
    chkInt("ur_bits", int'(edgeBits), int'(wb));
    chkInt("ur_done", doneCnt - d0, 1);

    // reset mid-pixel aborts the frame
    d0 = doneCnt;
    sendWord(24'($urandom()), 1'b1, 1'b0);
    idle(13 * BIT + 10);
    nReset = 1'b0;
    step();
    chkBit("abort_serClk", serClk, 1'b0);
    idle(4);
    nReset = 1'b1;
    idle(BITS + RST + 100);
    chkInt("abort_no_done", doneCnt - d0, 0);
    e0 = edgeCnt; d0 = doneCnt;
    wa = 24'($urandom());
    wb = 24'($urandom());
    sendWord(wa, 1'b0, 1'b1);
    sendWord(wb, 1'b1, 1'b0);
    waitDone(5000);
    chkInt("fresh_edges", edgeCnt - e0, 48);
    chkInt("fresh_bits", int'(edgeBits), int'(wb));
    chkInt("fresh_done", doneCnt - d0, 1);

    // randomized frames with random producer gaps, checked cycle by cycle
    for (int f = 0; f < 3; f++) begin
      d0 = doneCnt;
      n = int'($urandom_range(3, 1));
      for (int p = 0; p < n; p++) begin
        gap = ($urandom_range(3, 0) == 0) ? BITS + 50 : int'($urandom_range(80, 0));
        if (p > 0) idle(gap);
        sendWord(24'($urandom()), (p == n - 1), 1'b0);
      end
      waitDone(5000);
      chkInt("rand_done", doneCnt - d0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
